sqrt_fsm: RTL and testbench
===========================

# sqrt_fsm

Iterative integer square-root unit for 8-bit unsigned operands. It uses an odd-number accumulation state machine and returns the integer root (floor) on an 8-bit output register. It is a small arithmetic leaf block. It runs free while enabled, recomputing continuously from the input bus, so downstream logic can sample `dt_o` whenever `busy_o` is low.

## Interface
- No parameters; operand width fixed at 8 bits.
- `clk` input 1: single clock, rising-edge.
- `rstn_i` input 1: asynchronous, active-low reset.
- `enb_i` input 1: enable; a computation starts from IDLE while high.
- `dt_i` input 8: unsigned radicand, sampled only in IDLE.
- `dt_o` output 8: registered result, holds until the next completed computation.
- `busy_o` output 1: registered, high while a computation is in flight.
- Module name is `sqrt_fsm`; port names exactly as listed.

## Operation
- Internal registers:
  - `x` [7:0]: captured operand.
  - `d` [5:0]: step value, reaches 32 at most.
  - `s` [9:0]: running square, reaches 289 at most.
  - `state` [1:0].
- States are IDLE, CALC and DONE; the encoding is free.
- IDLE:
  - If `enb_i`=1: `x`<=`dt_i`, `s`<=4, `d`<=2, `busy_o`<=1, go to CALC.
  - If `enb_i`=0: stay in IDLE; all outputs hold.
- CALC:
  - If `s` <= `x`: `d`<=`d`+2 and `s`<=`s`+`d`+3, i.e. the new `s` is the old `s` plus the new `d` plus 1. Stay in CALC.
  - Otherwise go to DONE.
  - All comparisons are unsigned, with `x` zero-extended to 10 bits.
- DONE: `dt_o`<={3'b0, `d`[5:1]}, `busy_o`<=0, go to IDLE.
- Result is floor(sqrt(`dt_i`)) for `dt_i` >= 1.
- `dt_i`=0 yields 1 by default; this is an algorithm artifact, see Configuration.
- `dt_o` upper 4 bits are always 0; the maximum result is 15.
- `dt_i` and `enb_i` changes while busy are ignored; the operand is frozen in `x`.
- With `enb_i` held high, the block restarts immediately after DONE → IDLE, tracking `dt_i` continuously.

## Timing
- Reset (`rstn_i`=0, asynchronous) forces:
  - `state`=IDLE, `dt_o`=0, `busy_o`=0, `x`=0, `s`=0, `d`=0.
- Reset asserted mid-computation aborts it; `dt_o` is cleared to 0.
- Release is synchronous to the next `clk` rising edge.
- Let r = result and k = max(r−1, 0) CALC iterations.
- Counting edge 0 as the IDLE capture edge:
  - `busy_o` rises after edge 0.
  - `dt_o` updates and `busy_o` falls at edge k+2.
  - The next capture occurs at edge k+3.
- Worst case (`dt_i`=255, r=15, k=14): `dt_o` valid 16 cycles after capture.
- Best case (`dt_i` 0–3): 2 cycles.
- Restart period while enabled is k+3 cycles.
- `dt_o` is stable from the DONE edge until the next DONE edge.

## Configuration
- Macro `SQRT_ZERO_FIX_EN`.
- Undefined (default): `dt_i`=0 produces `dt_o`=1, as the raw algorithm gives.
- Defined: in DONE, if `x`=0 then `dt_o`<=0; all other values are unchanged.
- Timing is identical with or without the macro.

## Test plan
- Reset check: pulse `rstn_i` low for 5 ns with `clk` idle, then release → `dt_o`=0, `busy_o`=0.
- Exhaustive sweep: with `enb_i`=1, drive `dt_i`=0..255, waiting 250 cycles each → `dt_o`=floor(sqrt(n)), except n=0 gives 1 (0 with `SQRT_ZERO_FIX_EN`). Zero mismatches over 256 tests.
- Boundary values:
  - `dt_i`=3 → 1; 4 → 2; 8 → 2; 9 → 3.
  - `dt_i`=224 → 14; 225 → 15; 255 → 15.
- Latency: `dt_i`=255 captured at edge 0 → `busy_o` high for edges 1–15, `dt_o`=15 and `busy_o`=0 exactly at edge 16.
- Enable and operand-freeze: change `dt_i` from 100 to 4 while busy → result 10 is delivered; the next run gives 2. With `enb_i`=0 in IDLE, `busy_o` stays 0 and `dt_o` holds.
- Reset mid-run: assert `rstn_i` during CALC for `dt_i`=200 → `dt_o`=0 and `busy_o`=0 immediately; after release a fresh run gives 14.

Source files
------------

// File: rtl/sqrt_fsm_if.sv
// Operand/result bundle for sqrt_fsm: enable and radicand in, root and busy flag out.
// Handshake: enb_i is a level request sampled only while busy_o is low; busy_o high means the operand is frozen; dt_o is valid whenever busy_o is low.
interface sqrt_fsm_if;
  logic       enb_i;
  logic [7:0] dt_i;
  logic [7:0] dt_o;
  logic       busy_o;

  modport master (
    output enb_i,
    output dt_i,
    input  dt_o,
    input  busy_o
  );

  modport slave (
    input  enb_i,
    input  dt_i,
    output dt_o,
    output busy_o
  );
endinterface

// File: rtl/sqrt_fsm.sv
// Iterative 8-bit integer square root by odd-number accumulation (IDLE -> CALC -> DONE).
// Optional macro SQRT_ZERO_FIX_EN forces a zero operand to return 0 instead of 1.
module sqrt_fsm (
  input  logic       clk,
  input  logic       rstn_i,
  input  logic       enb_i,
  input  logic [7:0] dt_i,
  output logic [7:0] dt_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [5:0] d_q, d_d;
  logic [9:0] s_q, s_d;
  logic [7:0] dt_q, dt_d;
  logic       busy_q, busy_d;
  logic       s_le_x;

  assign s_le_x = (s_q <= {2'b00, x_q});

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      x_q     <= 8'd0;
      d_q     <= 6'd0;
      s_q     <= 10'd0;
      dt_q    <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      d_q     <= d_d;
      s_q     <= s_d;
      dt_q    <= dt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    d_d     = d_q;
    s_d     = s_q;
    dt_d    = dt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (enb_i) begin
          x_d     = dt_i;
          s_d     = 10'd4;
          d_d     = 6'd2;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // s tracks (d/2 + 1)^2; stop once it overshoots the operand.
        if (s_le_x) begin
          d_d = d_q + 6'd2;
          s_d = s_q + {4'b0000, d_q} + 10'd3;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef SQRT_ZERO_FIX_EN
        if (x_q == 8'd0) dt_d = 8'd0;
        else             dt_d = {3'b000, d_q[5:1]};
`else
        dt_d = {3'b000, d_q[5:1]};
`endif
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign dt_o   = dt_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_sqrt_fsm.sv
// Directed bench for sqrt_fsm: reset, boundaries, latency, operand freeze, mid-run reset, full sweep.
module tb_sqrt_fsm;

  logic clk;
  logic rstn_i;
  logic clk_run;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  sqrt_fsm_if sif ();

  sqrt_fsm dut (
    .clk    (clk),
    .rstn_i (rstn_i),
    .enb_i  (sif.enb_i),
    .dt_i   (sif.dt_i),
    .dt_o   (sif.dt_o),
    .busy_o (sif.busy_o)
  );

  // clock / reset
  initial begin
    clk     = 1'b0;
    clk_run = 1'b0;
  end

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return 8'(r);
  endfunction

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while (sif.busy_o === 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (sif.busy_o !== 1'b0) check(tag, {15'd0, sif.busy_o}, 16'd0);
  endtask

  task automatic wait_busy(input string tag);
    int cnt;
    cnt = 0;
    while (sif.busy_o !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (sif.busy_o !== 1'b1) check(tag, {15'd0, sif.busy_o}, 16'd1);
  endtask

  // single computation with enable dropped right after capture
  task automatic run_one(input logic [7:0] v);
    wait_idle("pre_run_timeout");
    sif.dt_i  = v;
    sif.enb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.enb_i = 1'b0;
    wait_idle("run_timeout");
  endtask

  logic [7:0] bnd_in  [7];
  logic [7:0] bnd_exp [7];
  logic [7:0] held;
  logic [7:0] zero_exp;

  initial begin
    checks    = 0;
    errors    = 0;
    sif.enb_i = 1'b0;
    sif.dt_i  = 8'd0;
    rstn_i    = 1'b1;
`ifdef SQRT_ZERO_FIX_EN
    zero_exp = 8'd0;
`else
    zero_exp = 8'd1;
`endif

    // reset pulse with clock idle
    #2 rstn_i = 1'b0;
    #5 rstn_i = 1'b1;
    #1;
    check("reset_dt_o", {8'd0, sif.dt_o}, 16'd0);
    check("reset_busy", {15'd0, sif.busy_o}, 16'd0);
    clk_run = 1'b1;
    @(negedge clk);

    // boundary vectors
    bnd_in  = '{8'd3, 8'd4, 8'd8, 8'd9, 8'd224, 8'd225, 8'd255};
    bnd_exp = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd14,  8'd15,  8'd15};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(bnd_exp[i]);
      run_one(bnd_in[i]);
      check($sformatf("boundary_%0d", bnd_in[i]), {8'd0, sif.dt_o}, {8'd0, exp_q.pop_front()});
    end
    run_one(8'd0);
    check("zero_operand", {8'd0, sif.dt_o}, {8'd0, zero_exp});

    // latency for 255: busy for edges 0..15, result at edge 16
    run_one(8'd4);
    sif.dt_i  = 8'd255;
    sif.enb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.enb_i = 1'b0;
    check("lat_busy_e0", {15'd0, sif.busy_o}, 16'd1);
    check("lat_hold_e0", {8'd0, sif.dt_o}, 16'd2);
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      check($sformatf("lat_busy_e%0d", e), {15'd0, sif.busy_o}, 16'd1);
    end
    @(negedge clk);
    check("lat_busy_e16", {15'd0, sif.busy_o}, 16'd0);
    check("lat_dt_e16", {8'd0, sif.dt_o}, 16'd15);

    // operand freeze while busy, then restart with enable still high
    sif.dt_i  = 8'd100;
    sif.enb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.dt_i = 8'd4;
    wait_idle("freeze_timeout");
    check("freeze_first", {8'd0, sif.dt_o}, 16'd10);
    wait_busy("restart_timeout");
    sif.enb_i = 1'b0;
    wait_idle("restart_done_timeout");
    check("freeze_second", {8'd0, sif.dt_o}, 16'd2);

    // enable low: nothing starts, result holds
    held = sif.dt_o;
    sif.dt_i = 8'd169;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_busy", {15'd0, sif.busy_o}, 16'd0);
    end
    check("idle_hold", {8'd0, sif.dt_o}, {8'd0, held});

    // reset during CALC
    sif.dt_i  = 8'd200;
    sif.enb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.enb_i = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy_before", {15'd0, sif.busy_o}, 16'd1);
    #2 rstn_i = 1'b0;
    #1;
    check("midrun_rst_dt_o", {8'd0, sif.dt_o}, 16'd0);
    check("midrun_rst_busy", {15'd0, sif.busy_o}, 16'd0);
    @(negedge clk);
    rstn_i = 1'b1;
    run_one(8'd200);
    check("after_rst_200", {8'd0, sif.dt_o}, 16'd14);

    // free-running sweep of every operand
    sif.enb_i = 1'b1;
    for (int n = 0; n < 256; n++) begin
      sif.dt_i = 8'(n);
      repeat (250) @(negedge clk);
      check($sformatf("sweep_%0d", n), {8'd0, sif.dt_o},
            {8'd0, (n == 0) ? zero_exp : isqrt(n)});
    end
    sif.enb_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
